// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the binary-to-BCD converter and the BCD datapath.
//   state_t       : converter FSM states (IDLE, SHIFT)
//   BCD_DIGIT_W   : bits per packed BCD digit
//   cnt_width()   : width of a counter that must hold the values 0..n
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // The shift counter has to reach BIN_W itself, so size it for n+1 values.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit: a digit of 5 or
// more gets 3 added so the following left shift carries into the next digit.
//   digit_i : 4-bit BCD digit before correction (0..9)
//   digit_o : corrected digit, ready to be shifted
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    if (digit_i >= BCD_DIGIT_W'(5)) begin
      digit_o = digit_i + BCD_DIGIT_W'(3);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, only looked at while idle
//   bin_in  : unsigned operand, captured on the edge that accepts start
//   busy    : high while shifts are in progress
//   done    : one-cycle pulse, bcd_out is new in that cycle
//   bcd_out : packed BCD result (digit 0 in [3:0]), held until next completion
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_shift_q, bin_shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;

  logic [SCR_W-1:0]       scratch_adj;
  logic [SCR_W+BIN_W-1:0] shifted;
  logic                   last_shift;

  // Every digit is corrected in parallel before the shift.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_o (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // The operand MSB falls into bit 0 of the scratch digits.
  assign shifted    = {scratch_adj, bin_shift_q} << 1;
  // cnt_q counts shifts already done, so this edge performs shift BIN_W.
  assign last_shift = (cnt_q == LAST_CNT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q == SHIFT);
    done    = done_q;
    bcd_out = bcd_q;
  end

  // Datapath next state
  always_comb begin
    bin_shift_d = bin_shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_shift_d = bin_in;
          scratch_d   = '0;
          cnt_d       = '0;
        end
      end
      SHIFT: begin
        {scratch_d, bin_shift_d} = shifted;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_shift) begin
          bcd_d  = shifted[SCR_W+BIN_W-1 -: SCR_W];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_shift_q <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      bin_shift_q <= bin_shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;

  logic        start_w;
  logic [9:0]  bin_w;
  logic        busy_w;
  logic        done_w;
  logic [15:0] bcd_w;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut_w (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_w),
    .bin_in  (bin_w),
    .busy    (busy_w),
    .done    (done_w),
    .bcd_out (bcd_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, packed 4 bits each.
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One conversion on the 8-bit instance; returns result, cycles from the
  // accepting edge to the done cycle, and number of busy cycles seen.
  task automatic run8(input logic [7:0] v, output logic [11:0] res,
                      output int lat, output int bcyc);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat  = 1;
    bcyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      lat++;
    end
    res = bcd_out;
    check("busy_low_at_done", {31'b0, busy}, 32'd0);
    $display("conv8 bin=%0d bcd=%h lat=%0d busy_cycles=%0d", v, res, lat, bcyc);
  endtask

  task automatic run10(input logic [9:0] v, output logic [15:0] res, output int lat);
    @(negedge clk);
    bin_w   = v;
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    lat = 1;
    while (done_w !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = bcd_w;
    $display("conv10 bin=%0d bcd=%h lat=%0d", v, res, lat);
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [11:0] res;
    logic [15:0] res_w;
    int lat, bcyc, done_cnt, first_done;

    tbl[0] = '{8'd255, 12'h255};
    tbl[1] = '{8'd0,   12'h000};
    tbl[2] = '{8'd99,  12'h099};
    tbl[3] = '{8'd100, 12'h100};
    tbl[4] = '{8'd1,   12'h001};
    tbl[5] = '{8'd9,   12'h009};
    tbl[6] = '{8'd10,  12'h010};
    tbl[7] = '{8'd128, 12'h128};

    rst_n   = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    start_w = 1'b0;
    bin_w   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  {31'b0, busy}, 32'd0);
    check("reset_done",  {31'b0, done}, 32'd0);
    check("reset_bcd",   {20'b0, bcd_out}, 32'd0);
    check("reset_bcd_w", {16'b0, bcd_w}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run8(tbl[i].bin, res, lat, bcyc);
      check("tbl_bcd",     {20'b0, res}, {20'b0, tbl[i].exp});
      check("tbl_latency", lat,  32'd9);
      check("tbl_busy",    bcyc, 32'd8);
      @(negedge clk);
      check("tbl_done_one_cycle", {31'b0, done}, 32'd0);
    end

    // Exhaustive back-to-back sweep: each start issued in the done cycle.
    @(negedge clk);
    bin_in = 8'd0;
    start  = 1'b1;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
        if (busy === 1'b1 && done === 1'b1) check("sweep_busy_done_excl", 32'd1, 32'd0);
        @(negedge clk);
        lat++;
      end
      $display("sweep bin=%0d bcd=%h lat=%0d", v, bcd_out, lat);
      check("sweep_bcd", {20'b0, bcd_out}, to_bcd(v));
      check("sweep_latency", lat, 32'd9);
      if (v < 255) begin
        bin_in = 8'(v + 1);
        start  = 1'b1;
      end
    end
    repeat (2) @(negedge clk);

    // start during a conversion is ignored
    bin_in = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt   = 0;
    first_done = 0;
    res = '0;
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = c;
          res = bcd_out;
        end
      end
      if (c == 3) begin
        bin_in = 8'd7;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    $display("ignore_start bin=200 bcd=%h first_done=%0d pulses=%0d", res, first_done, done_cnt);
    check("ignore_bcd",     {20'b0, res}, 32'h200);
    check("ignore_latency", first_done, 32'd9);
    check("ignore_pulses",  done_cnt, 32'd1);

    // Reset in the middle of a conversion
    bin_in = 8'd123;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("abort bin=123 busy=%0d done=%0d bcd=%h", busy, done, bcd_out);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_bcd",  {20'b0, bcd_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    run8(8'd42, res, lat, bcyc);
    check("after_abort_bcd",     {20'b0, res}, 32'h042);
    check("after_abort_latency", lat, 32'd9);

    // Wide instance: directed maximum then random operands with gaps
    run10(10'd1023, res_w, lat);
    check("w_bcd_1023", {16'b0, res_w}, 32'h1023);
    check("w_latency",  lat, 32'd11);
    for (int i = 0; i < 20; i++) begin
      logic [9:0] rv;
      rv = 10'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run10(rv, res_w, lat);
      check("w_rand_bcd",     {16'b0, res_w}, to_bcd(rv));
      check("w_rand_latency", lat, 32'd11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
